// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one block-wide data-memory port between the instruction cache
//   (read-only refills) and the data cache (write-backs and refills).
//   One requester's transaction is latched, driven onto the memory port until
//   the memory completes it, the block is returned, and the requester is
//   released for exactly one cycle. Contention is resolved round-robin and a
//   watchdog aborts a transaction whose memory never finishes.
//
// Ports
//   clock, reset          system clock, asynchronous active-low reset
//   i_read, i_address     icache refill request and block address
//   i_readdata            block returned to the icache (registered)
//   i_busywait            icache stall (combinational)
//   d_read, d_write       dcache refill / write-back request (write wins if both)
//   d_address, d_writedata dcache block address and write-back block
//   d_readdata            block returned to the dcache (registered)
//   d_busywait            dcache stall (combinational)
//   mem_read, mem_write   memory strobes (registered, never both high)
//   mem_address           memory block address (registered)
//   mem_writedata         memory write block (registered)
//   mem_readdata          memory read block
//   mem_busywait          memory stall
//   timeout_err           sticky watchdog flag, cleared only by reset
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic              timeout_err
);

    localparam int unsigned WD_W = 8;
    // Watchdog value at which the next busy cycle makes wd reach TIMEOUT.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Current registered state
    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic              seen_busy;
    logic [WD_W-1:0]   wd;

    // Next-state values
    state_t            state_nxt;
    owner_t            owner_nxt;
    owner_t            last_grant_nxt;
    logic              seen_busy_nxt;
    logic [WD_W-1:0]   wd_nxt;
    logic              mem_read_nxt;
    logic              mem_write_nxt;
    logic [ADDR_W-1:0] mem_address_nxt;
    logic [DATA_W-1:0] mem_writedata_nxt;
    logic [DATA_W-1:0] i_readdata_nxt;
    logic [DATA_W-1:0] d_readdata_nxt;
    logic              timeout_err_nxt;

    // Request decode and round-robin choice
    logic i_req;
    logic d_req;
    logic grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // The dcache wins when it is alone or when the icache was served last.
    assign grant_d = d_req & (~i_req | (last_grant == OWN_I));

    // Release the owner only during its single response cycle.
    assign i_busywait = i_req & ~((state == RESP) & (owner == OWN_I));
    assign d_busywait = d_req & ~((state == RESP) & (owner == OWN_D));

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_I;
            last_grant    <= OWN_D;
            seen_busy     <= 1'b0;
            wd            <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            owner         <= owner_nxt;
            last_grant    <= last_grant_nxt;
            seen_busy     <= seen_busy_nxt;
            wd            <= wd_nxt;
            mem_read      <= mem_read_nxt;
            mem_write     <= mem_write_nxt;
            mem_address   <= mem_address_nxt;
            mem_writedata <= mem_writedata_nxt;
            i_readdata    <= i_readdata_nxt;
            d_readdata    <= d_readdata_nxt;
            timeout_err   <= timeout_err_nxt;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt         = state;
        owner_nxt         = owner;
        last_grant_nxt    = last_grant;
        seen_busy_nxt     = seen_busy;
        wd_nxt            = wd;
        mem_read_nxt      = mem_read;
        mem_write_nxt     = mem_write;
        mem_address_nxt   = mem_address;
        mem_writedata_nxt = mem_writedata;
        i_readdata_nxt    = i_readdata;
        d_readdata_nxt    = d_readdata;
        timeout_err_nxt   = timeout_err;

        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    seen_busy_nxt = 1'b0;
                    wd_nxt        = '0;
                    if (grant_d) begin
                        // A simultaneous read and write request is a write-back.
                        owner_nxt         = OWN_D;
                        mem_read_nxt      = ~d_write;
                        mem_write_nxt     = d_write;
                        mem_address_nxt   = d_address;
                        mem_writedata_nxt = d_writedata;
                        state_nxt         = GNT_D;
                    end else begin
                        owner_nxt         = OWN_I;
                        mem_read_nxt      = 1'b1;
                        mem_write_nxt     = 1'b0;
                        mem_address_nxt   = i_address;
                        mem_writedata_nxt = '0;
                        state_nxt         = GNT_I;
                    end
                end
            end

            GNT_I, GNT_D: begin
                if (mem_busywait) begin
                    seen_busy_nxt = 1'b1;
                    if (wd == WD_LAST) begin
                        // Memory hung: abort and hand back an all-zero block.
                        wd_nxt          = WD_W'(TIMEOUT);
                        mem_read_nxt    = 1'b0;
                        mem_write_nxt   = 1'b0;
                        timeout_err_nxt = 1'b1;
                        if (owner == OWN_D) begin
                            d_readdata_nxt = '0;
                        end else begin
                            i_readdata_nxt = '0;
                        end
                        state_nxt = RESP;
                    end else begin
                        wd_nxt = wd + WD_W'(1);
                    end
                end else if (seen_busy) begin
                    // Completion only counts after memory has acknowledged with busy.
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    if (mem_read) begin
                        if (owner == OWN_D) begin
                            d_readdata_nxt = mem_readdata;
                        end else begin
                            i_readdata_nxt = mem_readdata;
                        end
                    end
                    last_grant_nxt = owner;
                    state_nxt      = RESP;
                end
            end

            // One cycle with no arbitration so a stale request is never re-granted.
            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
